// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-line saturating direction counters.
// Lookup is combinational on IFPC; resolved outcomes update one line per cycle.
// A registered mispredict pulse and a saturating mispredict counter track accuracy.
module branch_target_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned PC_LSB  = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      IFPC,
  output logic             HIT,
  output logic             PTAKEN,
  output logic [31:0]      PTARGET,
  input  logic             UPD,
  input  logic [31:0]      UPDPC,
  input  logic             UPDTAKEN,
  input  logic [31:0]      UPDTGT,
  input  logic             UPDPRED,
  input  logic             FLUSH,
  output logic             MISPRED,
  output logic [CNT_W-1:0] MISCNT
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - PC_LSB - IDX_W;

  localparam logic [CTR_W-1:0] CtrMax = '1;
  // Weakly taken is the MSB alone; weakly not taken sits just below it.
  localparam logic [CTR_W-1:0] CtrWt  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CtrWnt = CtrWt - CTR_W'(1);

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];

  logic             mispred_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_we;
  logic [CTR_W-1:0] up_ctr;
  logic [31:0]      up_tgt;
  logic             mis;

  if (PC_LSB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^{IFPC[PC_LSB-1:0], UPDPC[PC_LSB-1:0]};
  end

  assign lk_idx = IFPC[PC_LSB +: IDX_W];
  assign lk_tag = IFPC[31 -: TAG_W];
  assign up_idx = UPDPC[PC_LSB +: IDX_W];
  assign up_tag = UPDPC[31 -: TAG_W];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign mis    = UPD && (UPDPRED != UPDTAKEN);

  // Zero-latency lookup; returns pre-update contents when an update hits the same line.
  always_comb begin
    HIT     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    PTAKEN  = HIT && ctr_q[lk_idx][CTR_W-1];
    PTARGET = PTAKEN ? tgt_q[lk_idx] : IFPC + 32'd4;
  end

  // Next contents of the line addressed by UPDPC: train on hit, allocate on taken miss.
  always_comb begin
    up_we  = 1'b0;
    up_ctr = ctr_q[up_idx];
    up_tgt = tgt_q[up_idx];
    if (UPD) begin
      if (up_hit) begin
        up_we = 1'b1;
        if (UPDTAKEN) begin
          up_tgt = UPDTGT;
          if (ctr_q[up_idx] != CtrMax) up_ctr = ctr_q[up_idx] + CTR_W'(1);
        end else if (ctr_q[up_idx] != '0) begin
          up_ctr = ctr_q[up_idx] - CTR_W'(1);
        end
      end else if (UPDTAKEN) begin
        up_we  = 1'b1;
        up_ctr = CtrWt;
        up_tgt = UPDTGT;
      end
    end
  end

  // Line storage; FLUSH only drops valid bits and pre-empts any same-cycle line write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CtrWnt;
      end
    end else if (FLUSH) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (up_we) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      tgt_q[up_idx]   <= up_tgt;
      ctr_q[up_idx]   <= up_ctr;
    end
  end

  // Mispredict statistics; counted regardless of FLUSH, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mispred_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      mispred_q <= mis;
      if (mis && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign MISPRED = mispred_q;
  assign MISCNT  = cnt_q;

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised successor to the single-bit dynamic branch predictor in the pipeline controller.
- Direct-mapped branch target buffer of ENTRIES lines, each holding valid, tag, target and a CTR_W-bit saturating counter.
- IF stage looks up IFPC combinationally and gets a predicted direction and target. ID stage writes back resolved outcomes one update per cycle.
- Global FLUSH drops all lines on self-modifying-code detection.

Parameters:
- ENTRIES, 16, number of lines; power of two, at least 2. IDX_W = log2(ENTRIES).
- CTR_W, 2, saturating counter width, at least 1. CTR_W=1 reproduces the old single-bit scheme per line.
- PC_LSB, 2, low PC bits ignored for indexing (word-aligned instructions).
- CNT_W, 16, width of the mispredict statistics counter.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous active-high reset
- IFPC  in  32  fetch PC for lookup
- HIT  out  1  IFPC matches a valid line
- PTAKEN  out  1  predicted taken
- PTARGET  out  32  predicted next PC
- UPD  in  1  ID-stage branch/jump resolved this cycle
- UPDPC  in  32  PC of the resolved instruction
- UPDTAKEN  in  1  actual outcome
- UPDTGT  in  32  actual taken target
- UPDPRED  in  1  direction that was predicted for this instruction
- FLUSH  in  1  invalidate all lines (SMC)
- MISPRED  out  1  registered: the previous cycle's UPD mispredicted
- MISCNT  out  CNT_W  saturating mispredict count

Behaviour:
- Address split:
  - idx = PC[PC_LSB+IDX_W-1 : PC_LSB]
  - tag = PC[31 : PC_LSB+IDX_W]; TAG_W = 32-PC_LSB-IDX_W
- Lookup (combinational, zero latency):
  - HIT = valid[idx(IFPC)] && tag[idx] == tag(IFPC).
  - PTAKEN = HIT && ctr[idx][CTR_W-1].
  - PTARGET = target[idx] when PTAKEN, else IFPC+4 (modulo 2^32; 32'hFFFFFFFC wraps to 0).
- Update (registered, takes effect at the next CLK edge when UPD=1):
  - Hit at idx(UPDPC):
    - taken: ctr = min(ctr+1, 2^CTR_W-1); target = UPDTGT.
    - not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, UPDTAKEN=1: allocate (overwrite) the line with valid=1, tag=tag(UPDPC), target=UPDTGT, ctr = 2^(CTR_W-1) (weakly taken).
  - Miss, UPDTAKEN=0: no state change.
- No bypass: a lookup and an update to the same line in the same cycle return the pre-update contents. The new state is visible the cycle after.
- FLUSH: at the next edge, all valid bits are cleared; counters and targets are retained.
- FLUSH and UPD in the same cycle: FLUSH wins and the line update is dropped. MISPRED/MISCNT still account for that UPD.
- Statistics:
  - MISPRED is registered high for exactly one cycle after a cycle with UPD && (UPDPRED != UPDTAKEN).
  - MISCNT increments on the same condition and saturates at all-ones (no wrap).
  - MISCNT is cleared only by RST, not by FLUSH.
- Reset (asynchronous, immediate on RST assertion, including mid-update):
  - all valid=0; ctr=2^(CTR_W-1)-1 (weakly not taken); target=0.
  - MISPRED=0, MISCNT=0.
  - Resulting outputs: HIT=0, PTAKEN=0, PTARGET=IFPC+4.
- Removal of RST is synchronous to CLK. The first update is accepted on the first edge after deassertion.
- UPD with X on other update inputs while UPD=0 is ignored.

Test Plan:
- After RST, IFPC=0x00400010 -> HIT=0, PTAKEN=0, PTARGET=0x00400014; MISCNT=0.
- UPD with UPDPC=0x00400010, UPDTAKEN=1, UPDTGT=0x00400100, UPDPRED=0 -> next cycle lookup of 0x00400010 gives HIT=1, PTAKEN=1, PTARGET=0x00400100, ctr=2; MISPRED pulses one cycle; MISCNT=1.
- Same line, three not-taken updates then two taken (CTR_W=2) -> ctr goes 1,0,0 (saturated low), then 1,2. PTAKEN=0 after the 2nd not-taken, PTAKEN=1 after the final taken.
- Aliasing: UPDPC=0x00400050, ENTRIES=16 (same idx, different tag) with UPDTAKEN=1 -> line replaced. Lookup of 0x00400010 gives HIT=0; lookup of 0x00400050 gives HIT=1.
- FLUSH with simultaneous mispredicting UPD -> next cycle all HIT=0, the line is not allocated, MISCNT increments, MISPRED=1.
- CNT_W=2: five mispredicts -> MISCNT reads 1,2,3,3,3. Assert RST mid-sequence -> MISCNT=0 and HIT=0 immediately, without waiting for a clock edge.
